// File: rtl/sdram_port_arb.sv
// Multi-port request arbiter in front of a single SDRAM controller port.
// Bursty round-robin grant on the request side; an in-order tag FIFO routes responses back.
module sdram_port_arb #(
    parameter int NPORTS    = 4,
    parameter int AW        = 24,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int TAG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    p_valid,
    output logic [NPORTS-1:0]    p_ready,
    input  logic [NPORTS-1:0]    p_we,
    input  logic [NPORTS*AW-1:0] p_addr,
    input  logic [NPORTS*DW-1:0] p_data,
    output logic [NPORTS-1:0]    p_bvalid,
    output logic                 p_bwe,
    output logic [DW-1:0]        p_bdata,
    output logic                 m_avalid,
    output logic                 m_awe,
    output logic [AW-1:0]        m_aaddr,
    output logic [DW-1:0]        m_adata,
    input  logic                 m_aready,
    input  logic                 m_bvalid,
    input  logic                 m_bwe,
    input  logic [DW-1:0]        m_bdata,
    output logic                 err
);

    localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [7:0]  BC_RELOAD = 8'(MAX_BURST - 1);
    localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL  = (PW+1)'(TAG_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [GW-1:0] r_g;
    logic [7:0]    r_bc;
    logic [GW-1:0] w_g_nxt;
    logic [7:0]    w_bc_nxt;
    logic          w_cur_valid;
    logic          w_found;
    logic [GW-1:0] w_found_idx;
    logic          w_xfer;

    logic [GW-1:0] r_tag_mem [TAG_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_err;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic          w_pop;
    logic [GW-1:0] w_head;

    assign w_tag_full  = (r_count == CNT_FULL);
    assign w_tag_empty = (r_count == '0);
    assign w_xfer      = m_avalid && m_aready;
    assign w_pop       = m_bvalid && !w_tag_empty;
    assign w_head      = r_tag_mem[r_rptr];
    assign err         = r_err;

    // Grant state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g  <= '0;
            r_bc <= BC_RELOAD;
        end else begin
            r_g  <= w_g_nxt;
            r_bc <= w_bc_nxt;
        end
    end

    // Nearest valid port after r_g in circular order, r_g itself excluded
    always_comb begin : find_next
        int v_best;
        int v_dist;
        v_best      = NPORTS;
        v_dist      = 0;
        w_found     = 1'b0;
        w_found_idx = r_g;
        for (int i = 0; i < NPORTS; i++) begin
            v_dist = (i + NPORTS - int'(r_g)) % NPORTS;
            if (p_valid[i] && (v_dist != 0) && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_found     = 1'b1;
                w_found_idx = GW'(i);
            end
        end
    end

    always_comb begin
        w_g_nxt  = r_g;
        w_bc_nxt = r_bc;
        if (!w_cur_valid) begin
            if (w_found) begin
                w_g_nxt  = w_found_idx;
                w_bc_nxt = BC_RELOAD;
            end
        end else if (w_xfer) begin
            if (r_bc == 8'd0) begin
                w_bc_nxt = BC_RELOAD;
                if (w_found) begin
                    w_g_nxt = w_found_idx;
                end
            end else begin
                w_bc_nxt = r_bc - 8'd1;
            end
        end
    end

    // Request path: straight mux from the granted port, no registers
    always_comb begin
        w_cur_valid = 1'b0;
        m_awe       = 1'b0;
        m_aaddr     = '0;
        m_adata     = '0;
        p_ready     = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (r_g == GW'(i)) begin
                w_cur_valid = p_valid[i];
                m_awe       = p_we[i];
                m_aaddr     = p_addr[i*AW +: AW];
                m_adata     = p_data[i*DW +: DW];
                p_ready[i]  = m_aready && !w_tag_full && !rst;
            end
        end
        m_avalid = w_cur_valid && !w_tag_full && !rst;
    end

    // Tag FIFO control; pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_xfer, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (m_bvalid && w_tag_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_tag_mem[r_wptr] <= r_g;
        end
    end

    // Response path: strobe lands on the port recorded at the FIFO head
    always_comb begin
        p_bvalid = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_head == GW'(i)) begin
                p_bvalid[i] = w_pop;
            end
        end
        p_bwe   = m_bwe;
        p_bdata = m_bdata;
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: expected response routing is queued as requests are accepted.
module tb_sdram_port_arb;
    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int TD = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NP-1:0]    p_valid;
    logic [NP-1:0]    p_ready;
    logic [NP-1:0]    p_we;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_data;
    logic [NP-1:0]    p_bvalid;
    logic             p_bwe;
    logic [DW-1:0]    p_bdata;
    logic             m_avalid;
    logic             m_awe;
    logic [AW-1:0]    m_aaddr;
    logic [DW-1:0]    m_adata;
    logic             m_aready;
    logic             m_bvalid;
    logic             m_bwe;
    logic [DW-1:0]    m_bdata;
    logic             err;

    sdram_port_arb #(.NPORTS(NP), .AW(AW), .DW(DW), .MAX_BURST(MB), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_ready(p_ready), .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
        .p_bvalid(p_bvalid), .p_bwe(p_bwe), .p_bdata(p_bdata),
        .m_avalid(m_avalid), .m_awe(m_awe), .m_aaddr(m_aaddr), .m_adata(m_adata),
        .m_aready(m_aready), .m_bvalid(m_bvalid), .m_bwe(m_bwe), .m_bdata(m_bdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          we;
    } exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid  = '0;
        p_we     = '0;
        p_addr   = '0;
        p_data   = '0;
        m_aready = 1'b0;
        m_bvalid = 1'b0;
        m_bwe    = 1'b0;
        m_bdata  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        sb_q.delete();
        #1 rst = 1'b1;
        cyc();
        cyc();
        #1 rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        p_valid  = '1;
        m_aready = 1'b1;
        m_bvalid = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_vec++; if (p_ready !== 4'b0000) begin n_err++; $display("FAIL reset_p_ready: got %b want 0000", p_ready); end
        n_vec++; if (m_avalid !== 1'b0) begin n_err++; $display("FAIL reset_m_avalid: got %b want 0", m_avalid); end
        n_vec++; if (p_bvalid !== 4'b0000) begin n_err++; $display("FAIL reset_p_bvalid: got %b want 0000", p_bvalid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        cyc();
        cyc();
        idle_inputs();
        #1 rst = 1'b0;
        cyc();
        m_aready = 1'b1;
        #4;
        n_vec++; if (p_ready !== 4'b0001) begin n_err++; $display("FAIL reset_grant0: got %b want 0001", p_ready); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err_after: got %b want 0", err); end
        cyc();
    endtask

    task automatic test_bubble();
        exp_t e;
        logic [AW-1:0] a;
        apply_reset();
        p_valid  = 4'b0100;
        p_we     = 4'b0100;
        p_data   = {16'h0, 16'h1234, 32'h0};
        m_aready = 1'b1;
        a = 24'h00A000;
        p_addr = {{((NP-1)*AW){1'b0}}, a} << (2*AW);
        #4;
        n_vec++; if (m_avalid !== 1'b0) begin n_err++; $display("FAIL bubble_avalid: got %b want 0", m_avalid); end
        n_vec++; if (p_ready !== 4'b0001) begin n_err++; $display("FAIL bubble_g0: got %b want 0001", p_ready); end
        cyc();
        for (int t = 0; t < 3; t++) begin
            a = 24'h00A000 + 24'(t);
            p_addr = {{((NP-1)*AW){1'b0}}, a} << (2*AW);
            #4;
            n_vec++; if (p_ready !== 4'b0100) begin n_err++; $display("FAIL bubble_ready: got %b want 0100", p_ready); end
            n_vec++; if (m_avalid !== 1'b1 || m_awe !== 1'b1) begin n_err++; $display("FAIL bubble_req: got avalid=%b awe=%b want 1 1", m_avalid, m_awe); end
            n_vec++; if (m_aaddr !== a || m_adata !== 16'h1234) begin n_err++; $display("FAIL bubble_fields: got addr=%h data=%h want %h 1234", m_aaddr, m_adata, a); end
            sb_q.push_back('{2, 16'h0, 1'b1});
            cyc();
        end
        p_valid  = '0;
        m_aready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            m_bvalid = 1'b1;
            m_bwe    = 1'b1;
            #4;
            if (sb_q.size() == 0) begin
                n_vec++; n_err++; $display("FAIL bubble_sb_empty: got response want none");
            end else begin
                e = sb_q.pop_front();
                n_vec++; if (p_bvalid !== (4'b0001 << e.port)) begin n_err++; $display("FAIL bubble_bvalid: got %b want %b", p_bvalid, 4'b0001 << e.port); end
                n_vec++; if (p_bwe !== e.we) begin n_err++; $display("FAIL bubble_bwe: got %b want %b", p_bwe, e.we); end
            end
            cyc();
        end
        m_bvalid = 1'b0;
        #4;
        n_vec++; if (p_bvalid !== 4'b0000) begin n_err++; $display("FAIL bubble_no_extra: got %b want 0000", p_bvalid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bubble_err: got %b want 0", err); end
        cyc();
    endtask

    task automatic test_burst();
        exp_t e;
        int exp_g;
        int cnt;
        logic [DW-1:0] rd;
        apply_reset();
        p_valid  = '1;
        p_addr   = {24'h300000, 24'h200000, 24'h100000, 24'h000000};
        m_aready = 1'b1;
        exp_g = 0;
        cnt   = 0;
        for (int t = 0; t < 40; t++) begin
            rd       = 16'($urandom);
            m_bvalid = (sb_q.size() != 0);
            m_bwe    = 1'b0;
            m_bdata  = rd;
            #4;
            n_vec++; if (p_ready !== (4'b0001 << exp_g)) begin n_err++; $display("FAIL burst_grant t=%0d: got %b want %b", t, p_ready, 4'b0001 << exp_g); end
            n_vec++; if (m_avalid !== 1'b1) begin n_err++; $display("FAIL burst_nobubble t=%0d: got %b want 1", t, m_avalid); end
            if (m_bvalid) begin
                e = sb_q.pop_front();
                n_vec++; if (p_bvalid !== (4'b0001 << e.port) || p_bdata !== rd) begin n_err++; $display("FAIL burst_resp t=%0d: got %b/%h want %b/%h", t, p_bvalid, p_bdata, 4'b0001 << e.port, rd); end
            end
            sb_q.push_back('{exp_g, 16'h0, 1'b0});
            cnt++;
            if (cnt == MB) begin
                cnt   = 0;
                exp_g = (exp_g + 1) % NP;
            end
            cyc();
        end
        p_valid  = '0;
        m_bvalid = 1'b1;
        #4;
        e = sb_q.pop_front();
        n_vec++; if (p_bvalid !== (4'b0001 << e.port)) begin n_err++; $display("FAIL burst_drain: got %b want %b", p_bvalid, 4'b0001 << e.port); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL burst_err: got %b want 0", err); end
        cyc();
        m_bvalid = 1'b0;
    endtask

    task automatic test_full();
        exp_t e;
        apply_reset();
        p_valid  = 4'b0001;
        m_aready = 1'b1;
        for (int t = 0; t < TD; t++) begin
            #4;
            n_vec++; if (p_ready !== 4'b0001 || m_avalid !== 1'b1) begin n_err++; $display("FAIL full_accept t=%0d: got %b/%b want 0001/1", t, p_ready, m_avalid); end
            sb_q.push_back('{0, 16'h0, 1'b0});
            cyc();
        end
        for (int t = 0; t < 2; t++) begin
            #4;
            n_vec++; if (p_ready !== 4'b0000 || m_avalid !== 1'b0) begin n_err++; $display("FAIL full_block t=%0d: got %b/%b want 0000/0", t, p_ready, m_avalid); end
            cyc();
        end
        m_bvalid = 1'b1;
        m_bdata  = 16'hC0DE;
        #4;
        e = sb_q.pop_front();
        n_vec++; if (p_bvalid !== (4'b0001 << e.port) || p_bdata !== 16'hC0DE) begin n_err++; $display("FAIL full_pop: got %b/%h want %b/c0de", p_bvalid, p_bdata, 4'b0001 << e.port); end
        n_vec++; if (p_ready !== 4'b0000) begin n_err++; $display("FAIL full_pop_ready: got %b want 0000", p_ready); end
        cyc();
        m_bvalid = 1'b0;
        #4;
        n_vec++; if (p_ready !== 4'b0001 || m_avalid !== 1'b1) begin n_err++; $display("FAIL full_one_more: got %b/%b want 0001/1", p_ready, m_avalid); end
        sb_q.push_back('{0, 16'h0, 1'b0});
        cyc();
        #4;
        n_vec++; if (p_ready !== 4'b0000 || m_avalid !== 1'b0) begin n_err++; $display("FAIL full_again: got %b/%b want 0000/0", p_ready, m_avalid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", err); end
        cyc();
        p_valid = '0;
    endtask

    task automatic test_interleave();
        int reqs[6] = '{1, 3, 1, 3, 3, 1};
        pend_t pend_q[$];
        pend_t pr;
        exp_t e;
        logic [AW-1:0] a;
        int idx;
        apply_reset();
        m_aready = 1'b1;
        idx = 0;
        for (int c = 0; c < 60 && !(idx == 6 && sb_q.size() == 0); c++) begin
            a = 24'h000100 + 24'(idx * 24'h37) + 24'(reqs[(idx < 6) ? idx : 0] << 12);
            if (idx < 6) begin
                p_valid = 4'b0001 << reqs[idx];
                p_addr  = {{((NP-1)*AW){1'b0}}, a} << (reqs[idx]*AW);
            end else begin
                p_valid = '0;
            end
            m_bvalid = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == c) begin
                pr       = pend_q.pop_front();
                m_bvalid = 1'b1;
                m_bdata  = pr.data;
            end
            #4;
            if (m_bvalid) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL ilv_sb_empty c=%0d: got response want none", c);
                end else begin
                    e = sb_q.pop_front();
                    n_vec++; if (p_bvalid !== (4'b0001 << e.port)) begin n_err++; $display("FAIL ilv_port c=%0d: got %b want %b", c, p_bvalid, 4'b0001 << e.port); end
                    n_vec++; if (p_bdata !== e.data) begin n_err++; $display("FAIL ilv_data c=%0d: got %h want %h", c, p_bdata, e.data); end
                end
            end
            if (m_avalid && m_aready) begin
                pend_q.push_back('{c + 3, m_aaddr[DW-1:0] ^ 16'hA5A5});
            end
            if (idx < 6 && p_ready[reqs[idx]]) begin
                sb_q.push_back('{reqs[idx], a[DW-1:0] ^ 16'hA5A5, 1'b0});
                idx++;
            end
            cyc();
        end
        p_valid  = '0;
        m_bvalid = 1'b0;
        n_vec++; if (idx != 6 || sb_q.size() != 0) begin n_err++; $display("FAIL ilv_timeout: got issued=%0d pending=%0d want 6/0", idx, sb_q.size()); end
    endtask

    task automatic test_err();
        apply_reset();
        m_bvalid = 1'b1;
        m_bdata  = 16'h55AA;
        #4;
        n_vec++; if (p_bvalid !== 4'b0000) begin n_err++; $display("FAIL err_no_bvalid: got %b want 0000", p_bvalid); end
        cyc();
        m_bvalid = 1'b0;
        #4;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
        cyc();
        cyc();
        cyc();
        #4;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
        cyc();
        apply_reset();
        #4;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_cleared: got %b want 0", err); end
        cyc();
    endtask

    task automatic test_reset_outstanding();
        apply_reset();
        p_valid  = 4'b0100;
        m_aready = 1'b1;
        cyc();
        for (int t = 0; t < 5; t++) begin
            #4;
            n_vec++; if (p_ready !== 4'b0100) begin n_err++; $display("FAIL rst_issue t=%0d: got %b want 0100", t, p_ready); end
            cyc();
        end
        p_valid  = '1;
        m_bvalid = 1'b1;
        m_bdata  = 16'h0001;
        #1 rst = 1'b1;
        #1;
        n_vec++; if (p_ready !== 4'b0000 || m_avalid !== 1'b0) begin n_err++; $display("FAIL rst_async_req: got %b/%b want 0000/0", p_ready, m_avalid); end
        n_vec++; if (p_bvalid !== 4'b0000) begin n_err++; $display("FAIL rst_async_bvalid: got %b want 0000", p_bvalid); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_async_err: got %b want 0", err); end
        cyc();
        idle_inputs();
        #1 rst = 1'b0;
        cyc();
        p_valid  = '1;
        m_aready = 1'b1;
        m_bvalid = 1'b1;
        #4;
        n_vec++; if (p_bvalid !== 4'b0000) begin n_err++; $display("FAIL rst_stale_dropped: got %b want 0000", p_bvalid); end
        n_vec++; if (p_ready !== 4'b0001) begin n_err++; $display("FAIL rst_g0: got %b want 0001", p_ready); end
        cyc();
        m_bvalid = 1'b0;
        p_valid  = '0;
        #4;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL rst_stale_err: got %b want 1", err); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_bubble();
        test_burst();
        test_full();
        test_interleave();
        test_err();
        test_reset_outstanding();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL provide parameter NPORTS, default 4, number of requester ports (2..8).
REQ-002 SHALL provide parameter AW, default 24, request address width.
REQ-003 SHALL provide parameter DW, default 16, data width.
REQ-004 SHALL provide parameter MAX_BURST, default 8, maximum consecutive accepted requests per grant (1..255).
REQ-005 SHALL provide parameter TAG_DEPTH, default 8, outstanding-response tag FIFO depth (power of 2, >=4).
REQ-006 SHALL provide the following ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- p_valid  in  NPORTS  per-port request valid.
- p_ready  out  NPORTS  per-port request accepted.
- p_we  in  NPORTS  per-port write enable.
- p_addr  in  NPORTS*AW  per-port address; port i at bits [i*AW +: AW].
- p_data  in  NPORTS*DW  per-port write data; port i at bits [i*DW +: DW].
- p_bvalid  out  NPORTS  per-port response strobe.
- p_bwe  out  1  response type, broadcast (1 = write ack, 0 = read data).
- p_bdata  out  DW  response read data, broadcast.
- m_avalid, m_awe, m_aaddr[AW], m_adata[DW]  out  request to controller.
- m_aready  in  1  controller accepts request.
- m_bvalid, m_bwe, m_bdata[DW]  in  controller responses, strictly in request order.
- err  out  1  sticky: response received with tag FIFO empty.

Function
REQ-007 SHALL hold a registered grant index g (width clog2(NPORTS)); request path is combinational from port g.
REQ-008 SHALL drive m_avalid = p_valid[g] && !tag_full; m_awe/m_aaddr/m_adata = port g fields.
REQ-009 SHALL drive p_ready[i] = (i == g) && m_aready && !tag_full && !rst; all other p_ready bits 0.
REQ-010 SHALL count a transfer when m_avalid && m_aready.
REQ-011 SHALL keep burst counter bc: reloaded to MAX_BURST-1 on every grant change; decremented on each transfer while nonzero.
REQ-012 SHALL, at a clock edge where a transfer occurs with bc == 0, move g to the first port after g in circular order (g+1 .. g-1) with p_valid high; if none, g holds and bc reloads.
REQ-013 SHALL, at an edge where p_valid[g] == 0, move g to the first valid port in the same circular order (one-cycle bubble); if no port is valid, g holds.
REQ-014 SHALL not change g on edges where p_valid[g] is high and a transfer did not occur with bc == 0 (stall on m_aready or tag_full holds the grant).
REQ-015 SHALL push g into the tag FIFO on every transfer, for reads and writes alike.
REQ-016 SHALL pop the tag FIFO on every m_bvalid, driving p_bvalid[head] = m_bvalid with p_bwe = m_bwe and p_bdata = m_bdata, all combinational.
REQ-017 SHALL allow a push and a pop in the same cycle, occupancy unchanged; pointer wrap at TAG_DEPTH.
REQ-018 SHALL assert tag_full when occupancy == TAG_DEPTH, blocking new transfers until a pop.
REQ-019 SHALL, on m_bvalid with the FIFO empty, drive no p_bvalid, leave pointers unchanged, and set err until reset.
REQ-020 SHALL keep latency zero: no added cycles on request or response paths beyond the grant switch of REQ-012/013.

Reset
REQ-021 SHALL, while rst is high, force: g = 0, bc = MAX_BURST-1, tag FIFO empty, err = 0, p_ready = 0, m_avalid = 0, p_bvalid = 0.
REQ-022 SHALL drop responses for transfers issued before a reset; after release, a stale m_bvalid sets err per REQ-019.

Verification
REQ-023 Bench SHALL cover: only port 2 valid, 3 writes, m_aready = 1 -> cycle 1 is a bubble (g 0->2); 3 transfers follow; p_bvalid[2] pulses 3 times with p_bwe = 1.
REQ-024 Bench SHALL cover: all 4 ports continuously valid, MAX_BURST = 8 -> grant order 0,1,2,3,0 with exactly 8 transfers per grant and no bubbles.
REQ-025 Bench SHALL cover: m_bvalid held low, port 0 issues reads -> 8 transfers accepted, then p_ready[0] = 0; one m_bvalid -> exactly one more transfer, no overflow.
REQ-026 Bench SHALL cover: interleaved reads from ports 1 and 3, responses returned 3 cycles later in order -> each p_bvalid lands on the issuing port with matching p_bdata.
REQ-027 Bench SHALL cover: m_bvalid pulse with no outstanding requests -> err = 1, all p_bvalid = 0; err persists until rst.
REQ-028 Bench SHALL cover: rst asserted with 5 tags outstanding -> all outputs at reset values immediately; after release, occupancy = 0 and g = 0.
